// File: rtl/LDPC_pkg.sv
// Shared LDPC types and sizes.
//   MAX_ZC  : largest lifting size, which is also the column word width
//   BG_Type : base-graph selector. BG_NONE and any unlisted encoding are invalid.
package LDPC_pkg;

   localparam int unsigned MAX_ZC = 384;

   typedef enum logic [1:0] {
      BG_NONE = 2'd0,
      BG1     = 2'd1,
      BG2     = 2'd2
   } BG_Type;

endpackage

// File: rtl/msg_col_buffer.sv
// msg_col_buffer: two-bank ping-pong store for segmented message columns.
// The writer fills one bank with a block's kb columns (22 for BG1, 10 for BG2).
// The parity core reads the other bank at random column addresses and hands
// it back with frame_release.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   segmented_msg_block [MAX_ZC] column word, qualified by new_seg_msg_block
//   zc [9], BG                   block parameters, sampled on column 0
//   rd_en, rd_col [5]            column read request
//   rd_data [MAX_ZC], rd_valid   read response, one cycle after rd_en
//   frame_release                consumer is done with the read bank
//   frame_ready/cols/zc/bg       status and metadata of the read bank
//   wr_busy                      write bank is partially filled
//   overflow                     sticky, set when a column was dropped
module msg_col_buffer #(
   parameter int unsigned MAX_ZC   = LDPC_pkg::MAX_ZC,
   parameter int unsigned MAX_COLS = 22
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [MAX_ZC-1:0]      segmented_msg_block,
   input  logic                   new_seg_msg_block,
   input  logic [8:0]             zc,
   input  LDPC_pkg::BG_Type       BG,
   input  logic                   rd_en,
   input  logic [4:0]             rd_col,
   input  logic                   frame_release,
   output logic [MAX_ZC-1:0]      rd_data,
   output logic                   rd_valid,
   output logic                   frame_ready,
   output logic [4:0]             frame_cols,
   output logic [8:0]             frame_zc,
   output LDPC_pkg::BG_Type       frame_bg,
   output logic                   wr_busy,
   output logic                   overflow
);

   localparam logic [4:0] BG1_COLS = 5'd22;
   localparam logic [4:0] BG2_COLS = 5'd10;

   // Column storage; contents are not reset.
   logic [MAX_ZC-1:0] mem [2][MAX_COLS];

   // Per-bank metadata and pointers.
   logic [1:0]       full;
   logic [4:0]       cols_m [2];
   logic [8:0]       zc_m   [2];
   LDPC_pkg::BG_Type bg_m   [2];
   logic             wr_bank;
   logic             rd_bank;
   logic [4:0]       wr_col;

   // Write-side decode.
   logic              first_c;
   logic              bg_ok_c;
   logic [4:0]        new_cols_c;
   logic [4:0]        cur_cols_c;
   logic [8:0]        cur_zc_c;
   logic              blocked_c;
   logic              accept_c;
   logic              drop_c;
   logic              last_c;
   logic              release_c;
   logic [MAX_ZC-1:0] mask_c;
   logic [MAX_ZC-1:0] wr_word_c;

   // Column 0 takes zc/BG from the inputs. Later columns use the values latched for the bank.
   always_comb begin
      first_c    = (wr_col == 5'd0);
      bg_ok_c    = (BG == LDPC_pkg::BG1) || (BG == LDPC_pkg::BG2);
      new_cols_c = (BG == LDPC_pkg::BG1) ? BG1_COLS : BG2_COLS;
      cur_cols_c = first_c ? new_cols_c : cols_m[wr_bank];
      cur_zc_c   = first_c ? zc : zc_m[wr_bank];
      blocked_c  = full[wr_bank] || (first_c && !bg_ok_c);
      accept_c   = new_seg_msg_block && !blocked_c;
      drop_c     = new_seg_msg_block && blocked_c;
      last_c     = accept_c && (wr_col == (cur_cols_c - 5'd1));
      release_c  = frame_release && full[rd_bank];
   end

   // Bits at or above the block's zc are stored as zero.
   always_comb begin
      mask_c = '0;
      for (int unsigned i = 0; i < MAX_ZC; i++) begin
         mask_c[i] = (i < 32'(cur_zc_c));
      end
      wr_word_c = segmented_msg_block & mask_c;
   end

   // Column store. It has no reset because every column is written before it is read.
   always_ff @(posedge clk) begin
      if (accept_c) begin
         mem[wr_bank][wr_col] <= wr_word_c;
      end
   end

   // Pointers, metadata, full flags and overflow.
   // Completion and release never address the same bank in one cycle:
   // completion needs the bank empty and release needs it full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_col   <= '0;
         overflow <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            cols_m[b] <= '0;
            zc_m[b]   <= '0;
            bg_m[b]   <= LDPC_pkg::BG_NONE;
         end
      end else begin
         if (accept_c) begin
            if (first_c) begin
               cols_m[wr_bank] <= new_cols_c;
               zc_m[wr_bank]   <= zc;
               bg_m[wr_bank]   <= BG;
            end
            if (last_c) begin
               full[wr_bank] <= 1'b1;
               wr_col        <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_col <= wr_col + 5'd1;
            end
         end
         if (drop_c) begin
            overflow <= 1'b1;
         end
         if (release_c) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   // Read port. Addresses past the block or reads of a non-ready bank return zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en && full[rd_bank] && (rd_col < cols_m[rd_bank])) begin
            rd_data <= mem[rd_bank][rd_col];
         end else begin
            rd_data <= '0;
         end
      end
   end

   // Status is taken from the current read bank and reads zero when that bank is not ready.
   always_comb begin
      frame_ready = full[rd_bank];
      frame_cols  = frame_ready ? cols_m[rd_bank] : 5'd0;
      frame_zc    = frame_ready ? zc_m[rd_bank] : 9'd0;
      frame_bg    = frame_ready ? bg_m[rd_bank] : LDPC_pkg::BG_NONE;
      wr_busy     = (wr_col != 5'd0);
   end

endmodule

// File: doc/msg_col_buffer.md
Name: msg_col_buffer

Overview:
- Downstream of the message segmentation/filler stage. Captures the Zc-wide segmented message columns it emits, one column per cycle with new_seg_msg_block high.
- Assembles each code block's kb columns (22 for BG1, 10 for BG2) in a two-bank ping-pong buffer.
- Presents each complete block to the LDPC parity core through a random-access column read port with a release handshake.

Parameters:
- MAX_ZC, 384 (from LDPC_pkg): column word width.
- MAX_COLS, 22: columns per bank; covers BG1_MSG_COL_COUNT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- segmented_msg_block  in  MAX_ZC  segmented column word.
- new_seg_msg_block  in  1  column valid; each high cycle is one column.
- zc  in  9  lifting size of the current block.
- BG  in  BG_Type  base graph of the current block.
- rd_en  in  1  column read request.
- rd_col  in  5  column address for the read.
- frame_release  in  1  one-cycle pulse; consumer is done with the current read bank.
- rd_data  out  MAX_ZC  read column, valid one cycle after rd_en.
- rd_valid  out  1  qualifies rd_data.
- frame_ready  out  1  read bank holds a complete block.
- frame_cols  out  5  column count of the ready block (22 or 10).
- frame_zc  out  9  zc latched for the ready block.
- frame_bg  out  BG_Type  BG latched for the ready block.
- wr_busy  out  1  write bank is partially filled.
- overflow  out  1  sticky; a column was dropped.

Behaviour:
- Storage: 2 banks x MAX_COLS x MAX_ZC. Per-bank metadata: full flag, cols, zc, BG. Pointers: wr_bank, rd_bank, wr_col (5b).
- Reset: all flags, pointers, metadata, rd_data, rd_valid and overflow are 0; frame_ready is 0. Bank contents do not need reset.
- Write, first column (wr_col==0):
  - Latch zc, plus cols = 22 for BG1 or 10 for BG2, into the write bank's metadata.
  - If BG is neither BG1 nor BG2, drop the column and set overflow.
- Write, every accepted column: store word[i] for i<zc and 0 for i>=zc into bank[wr_bank][wr_col], then wr_col++. zc and BG changes mid-block are ignored; the latched values apply.
- Block complete: the cycle the column with wr_col==cols-1 is written, set the bank full, set wr_col=0 and toggle wr_bank. This is visible as frame_ready on the next cycle if it is the read bank.
- Write blocked: a new_seg_msg_block arriving while bank[wr_bank] is full is dropped, overflow is set, and wr_col is unchanged.
- wr_busy = (wr_col != 0).
- Read:
  - rd_en at cycle t gives rd_data = bank[rd_bank][rd_col] and rd_valid=1 at t+1.
  - If rd_col >= frame_cols or frame_ready==0, rd_data=0 and rd_valid=1.
  - rd_valid is 0 in cycles following no rd_en.
- frame_ready = full[rd_bank]. frame_cols, frame_zc and frame_bg come from rd_bank metadata and read 0 when not ready.
- frame_release while frame_ready: clear full[rd_bank] and toggle rd_bank. Release while not ready is ignored.
- Simultaneous events:
  - Release and the final write to the other bank in the same cycle both take effect.
  - Release and a write into the just-released bank in the same cycle cannot occur, since that bank was full and the write was dropped.
  - rd_en in the release cycle reads the old rd_bank.
- Throughput: 1 column per cycle sustained. With two banks, the writer never stalls if the consumer releases within one block time.
- Reset mid-block: the partial block is discarded and the next column is treated as column 0.

Test Plan:
- BG1, zc=384: 22 consecutive columns with word c = {12{32'(c)}} -> frame_ready rises the cycle after column 21; frame_cols=22, frame_zc=384; rd_col=5 returns {12{32'd5}} one cycle after rd_en; wr_busy is low at the end.
- BG2, zc=52, columns with all bits set -> frame_cols=10; every rd_data has bits[51:0]=1 and bits[383:52]=0; rd_col=12 returns 0 with rd_valid=1.
- Back-to-back BG1 blocks A then B with no release -> A ready; B fills bank 1; the first column of a third block C sets overflow. Release A -> frame_ready stays 1 with B's metadata, and rd_col=0 returns B's column 0.
- Release on the same cycle as the final write to the other bank -> the next cycle shows frame_ready=1 with the new bank; no overflow, no lost block.
- Assert reset_n low after 7 of 22 columns, then send 22 fresh columns -> frame_ready after the 22nd; column 0 holds the first post-reset word.
- frame_release pulse with frame_ready=0 -> no pointer change; the following block still lands in bank 0 and reads correctly.
